// File: rtl/mul_div_engine_if.sv
// Handshake and operand bundle between the phase-clock controller and the RV32M mul/div unit.
// The master drives the request and operands; the slave returns the result and stall flag.
interface mul_div_engine_if #(
  parameter int XLEN = 32
);
  logic            start_req;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] result;
  logic            alu_complete;

  modport master (
    output start_req, funct3, op_a, op_b,
    input  result, alu_complete
  );

  modport slave (
    input  start_req, funct3, op_a, op_b,
    output result, alu_complete
  );
endinterface

// File: rtl/mul_div_engine.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-subtract step per clock.
// alu_complete stays low while busy so the phase-clock generator stalls the pipeline.
module mul_div_engine #(
  parameter int XLEN = 32
) (
  input logic             clk_100M,
  input logic             rst,
  mul_div_engine_if.slave bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  logic [1:0]        r_state;
  logic [2:0]        r_op;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_operand;
  logic              r_negMain;
  logic              r_negRem;
  logic              r_special;
  logic [CW-1:0]     r_count;
  logic              r_startD;
  logic [XLEN-1:0]   r_result;
  logic              r_aluComplete;

  logic              w_startPulse;
  logic              w_isDiv;
  logic              w_aSigned;
  logic              w_bSigned;
  logic              w_aNeg;
  logic              w_bNeg;
  logic [XLEN-1:0]   w_aMag;
  logic [XLEN-1:0]   w_bMag;
  logic              w_divZero;
  logic              w_divOvf;
  logic              w_special;
  logic [XLEN-1:0]   w_preset;
  logic [XLEN:0]     w_mulSum;
  logic [2*XLEN-1:0] w_mulNext;
  logic [XLEN:0]     w_remShift;
  logic [XLEN:0]     w_remSub;
  logic              w_fits;
  logic [2*XLEN-1:0] w_divNext;
  logic [2*XLEN-1:0] w_prodFinal;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_final;

  assign w_startPulse = bus.start_req & ~r_startD;
  assign w_isDiv      = bus.funct3[2];
  assign w_aSigned    = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd2) ||
                        (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
  assign w_bSigned    = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd4) ||
                        (bus.funct3 == 3'd6);
  assign w_aNeg       = w_aSigned & bus.op_a[XLEN-1];
  assign w_bNeg       = w_bSigned & bus.op_b[XLEN-1];
  assign w_aMag       = w_aNeg ? -bus.op_a : bus.op_a;
  assign w_bMag       = w_bNeg ? -bus.op_b : bus.op_b;

  // The signed overflow case (most-negative / -1) only exists for DIV/REM, which are the signed divides.
  assign w_divZero = (bus.op_b == '0);
  assign w_divOvf  = w_aSigned & (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) & (bus.op_b == '1);
  assign w_special = w_isDiv & (w_divZero | w_divOvf);

  always_comb begin
    w_preset = '0;
    if (w_divZero) begin
      w_preset = bus.funct3[1] ? bus.op_a : '1;
    end else begin
      w_preset = bus.funct3[1] ? '0 : bus.op_a;
    end
  end

  // Multiply: high half accumulates, low half holds the multiplier and shifts out one bit per step.
  assign w_mulSum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_operand : {XLEN{1'b0}})};
  assign w_mulNext = {w_mulSum, r_acc[XLEN-1:1]};

  // Divide: high half is the partial remainder; quotient bits enter at the bottom as the dividend leaves.
  assign w_remShift = r_acc[2*XLEN-1:XLEN-1];
  assign w_fits     = (w_remShift >= {1'b0, r_operand});
  assign w_remSub   = w_remShift - {1'b0, r_operand};
  assign w_divNext  = {(w_fits ? w_remSub[XLEN-1:0] : w_remShift[XLEN-1:0]),
                       r_acc[XLEN-2:0], w_fits};

  assign w_prodFinal = r_negMain ? -r_acc : r_acc;
  assign w_quot      = r_negMain ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem       = r_negRem ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_final = '0;
    if (r_special) begin
      w_final = r_acc[XLEN-1:0];
    end else begin
      case (r_op)
        3'd0:                 w_final = w_prodFinal[XLEN-1:0];
        3'd1, 3'd2, 3'd3:     w_final = w_prodFinal[2*XLEN-1:XLEN];
        3'd4, 3'd5:           w_final = w_quot;
        default:              w_final = w_rem;
      endcase
    end
  end

  // start_d resets high so a request already asserted when reset releases is not taken as a start.
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_op          <= '0;
      r_acc         <= '0;
      r_operand     <= '0;
      r_negMain     <= 1'b0;
      r_negRem      <= 1'b0;
      r_special     <= 1'b0;
      r_count       <= '0;
      r_startD      <= 1'b1;
      r_result      <= '0;
      r_aluComplete <= 1'b1;
    end else begin
      r_startD <= bus.start_req;
      case (r_state)
        ST_IDLE: begin
          if (w_startPulse) begin
            r_op          <= bus.funct3;
            r_aluComplete <= 1'b0;
            r_negMain     <= w_aNeg ^ w_bNeg;
            r_negRem      <= w_aNeg;
            r_count       <= '0;
            if (w_special) begin
              r_special <= 1'b1;
              r_acc     <= {{XLEN{1'b0}}, w_preset};
              r_state   <= ST_FIX;
            end else begin
              r_special <= 1'b0;
              r_acc     <= {{XLEN{1'b0}}, (w_isDiv ? w_aMag : w_bMag)};
              r_operand <= w_isDiv ? w_bMag : w_aMag;
              r_state   <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          r_acc   <= r_op[2] ? w_divNext : w_mulNext;
          r_count <= r_count + 1'b1;
          if (r_count == CW'(XLEN-1)) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          r_result      <= w_final;
          r_aluComplete <= 1'b1;
          r_state       <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.result       = r_result;
  assign bus.alu_complete = r_aluComplete;

endmodule
